piece_bag_gen: RTL

//  Parametrised successor to the single-register piece picker. Deals Tetris piece IDs using a
//  "bag" rule: every group of NUM_PIECES consecutive deals is a permutation of 1..NUM_PIECES.

---
 rtl/piece_bag_gen.sv | 72 +++++++
 1 files changed

// File: rtl/piece_bag_gen.sv
// piece_bag_gen: bag-rule Tetris piece dealer with LFSR-seeded draws and a preview queue
module piece_bag_gen #(
  parameter int NUM_PIECES = 7,
  parameter int PIECE_W = 4,
  parameter int PREVIEW_DEPTH = 3,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               take,
  input  logic                               seed_load,
  input  logic [LFSR_W-1:0]                  seed_val,
  output logic [PIECE_W-1:0]                 piece,
  output logic                               piece_valid,
  output logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview,
  output logic [3:0]                         count,
  output logic [NUM_PIECES-1:0]              bag_left,
  output logic                               underflow
);
  localparam logic [3:0] DEPTH = 4'(PREVIEW_DEPTH);
  localparam logic [PIECE_W-1:0] NP = PIECE_W'(NUM_PIECES);
  localparam logic [7:0] NP8 = 8'(NUM_PIECES);
  typedef enum logic [1:0] {IDLE, SEED_ST, SCAN} state_t;
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [PIECE_W-1:0] cand, cand_n;
  logic [NUM_PIECES-1:0] cand_oh, bag_clr, bag_n;
  logic [PREVIEW_DEPTH*PIECE_W-1:0] q_n;
  logic [3:0] count_n, idx;
  logic hit, pop;
  always_comb begin
    cand_oh = NUM_PIECES'(1) << (cand - 1'b1);
    hit = state == SCAN && (bag_left & cand_oh) != '0;
    pop = take && count != '0;
    bag_clr = bag_left & ~cand_oh;
    bag_n = hit ? (bag_clr == '0 ? '1 : bag_clr) : bag_left;
    count_n = count + 4'(hit) - 4'(pop);
    idx = count - 4'(pop);
    q_n = pop ? preview >> PIECE_W : preview;
    if (hit) q_n[idx*PIECE_W +: PIECE_W] = cand;
    cand_n = state == SEED_ST ? PIECE_W'(lfsr[7:0] % NP8) + 1'b1 :
             (state == SCAN && !hit) ? (cand == NP ? PIECE_W'(1) : cand + 1'b1) : cand;
    state_n = state == IDLE ? (count < DEPTH ? SEED_ST : IDLE) :
              state == SEED_ST ? SCAN :
              hit ? (count_n < DEPTH ? SEED_ST : IDLE) : SCAN;
    lfsr_n = seed_load ? (seed_val == '0 ? LFSR_W'(1) : seed_val) :
             (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED == '0 ? LFSR_W'(1) : SEED;
      state <= SEED_ST;
      cand <= PIECE_W'(1);
      bag_left <= '1;
      preview <= '0;
      count <= '0;
      underflow <= 1'b0;
    end else begin
      lfsr <= lfsr_n;
      state <= state_n;
      cand <= cand_n;
      bag_left <= bag_n;
      preview <= q_n;
      count <= count_n;
      underflow <= underflow | (take && count == '0);
    end
  end
  assign piece = preview[PIECE_W-1:0];
  assign piece_valid = count != '0;
endmodule
